// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller.
// Holds the op_class and err encodings, the controller FSM state encoding,
// default bus widths and a small helper that classifies memory operations.
package mem_stage_ctrl_pkg;

    localparam int unsigned DefDataW      = 16;
    localparam int unsigned DefRegAw      = 3;
    localparam int unsigned DefRowD       = 8;
    localparam int unsigned DefTimeoutCyc = 64;

    typedef enum logic [1:0] {
        OpNop   = 2'b00,
        OpLoad  = 2'b01,
        OpStore = 2'b10,
        OpAlu   = 2'b11
    } op_class_e;

    typedef enum logic [1:0] {
        ErrOk      = 2'b00,
        ErrAddr    = 2'b01,
        ErrTimeout = 2'b10
    } err_e;

    typedef enum logic [3:0] {
        StIdle,
        StSetup,
        StFlush,
        StFlushWait,
        StReq,
        StWb,
        StRelease,
        StClrWait,
        StFin
    } state_e;

    // LOAD and STORE carry an address in op_result and are range checked.
    function automatic logic is_mem_op(op_class_e cls);
        return (cls == OpLoad) || (cls == OpStore);
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Bundle of the execute-side operation handshake, the Data_Memory request /
// response signals and the register-file write-back port.
// master: the memory-stage controller. slave: execute stage, Data_Memory and
// register file as seen from the other side.
interface mem_stage_ctrl_if
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned REG_AW = DefRegAw
);

    // Execute stage -> controller
    logic              op_valid;
    op_class_e         op_class;
    logic [DATA_W-1:0] op_result;
    logic [DATA_W-1:0] op_store_data;
    logic [REG_AW-1:0] op_dest;
    logic              op_ready;

    // Controller <-> Data_Memory
    logic              memRead;
    logic              memWrite;
    logic              memReadWrite;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] rd2;
    logic              isALUFinished;
    logic [DATA_W-1:0] rdata;
    logic              rdata_flag;
    logic              fetchNextInst;

    // Write-back and completion
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              done;
    err_e              err;

    modport master (
        input  op_valid, op_class, op_result, op_store_data, op_dest,
        output op_ready,
        output memRead, memWrite, memReadWrite, result, rd2, isALUFinished, fetchNextInst,
        input  rdata, rdata_flag,
        output wb_en, wb_addr, wb_data, done, err
    );

    modport slave (
        output op_valid, op_class, op_result, op_store_data, op_dest,
        input  op_ready,
        input  memRead, memWrite, memReadWrite, result, rd2, isALUFinished, fetchNextInst,
        output rdata, rdata_flag,
        input  wb_en, wb_addr, wb_data, done, err
    );

endinterface

// File: rtl/mem_req_timer.sv
// Wait-state timer for the memory-stage controller.
// Ports: clk, rst (async, active high); clr zeroes the count; inc advances it;
// expired is high once TIMEOUT_CYC wait cycles (including the current one)
// have been spent.
module mem_req_timer #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CntW = 16;

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    // Count starts at 0 on the first wait cycle, so the last allowed cycle
    // is TIMEOUT_CYC-1.
    assign expired = (cnt_q >= CntW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: initiator side of the Data_Memory handshake.
// Ports: clk, rst (async, active high); bus (mem_stage_ctrl_if.master) carries
// the op_valid/op_ready operation handshake, the one-hot memory request with
// result/rd2 and the isALUFinished strobe, the rdata/rdata_flag response with
// the fetchNextInst release pulse, the register write-back port and done/err.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned ROW_D       = DefRowD,
    parameter int unsigned REG_AW      = DefRegAw,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
    input logic              clk,
    input logic              rst,
    mem_stage_ctrl_if.master bus
);

    state_e            state_q, state_d;
    op_class_e         cls_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] rd2_q;
    logic [REG_AW-1:0] dest_q;
    err_e              err_q, err_d;
    logic              capture;

    logic flag_meta_q, flag_sync_q;
    logic timer_clr, timer_inc, timer_expired;
    logic ctrl_active, wb_fire;

    // rdata_flag comes from another timing domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_meta_q <= 1'b0;
            flag_sync_q <= 1'b0;
        end else begin
            flag_meta_q <= bus.rdata_flag;
            flag_sync_q <= flag_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cls_q    <= OpNop;
            result_q <= '0;
            rd2_q    <= '0;
            dest_q   <= '0;
            err_q    <= ErrOk;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (capture) begin
                cls_q    <= bus.op_class;
                result_q <= bus.op_result;
                rd2_q    <= bus.op_store_data;
                dest_q   <= bus.op_dest;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        capture   = 1'b0;
        timer_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.op_valid) begin
                    capture = 1'b1;
                    err_d   = ErrOk;
                    if (bus.op_class == OpNop) begin
                        state_d = StFin;
                    end else if (is_mem_op(bus.op_class) &&
                                 (bus.op_result >= DATA_W'(ROW_D))) begin
                        err_d   = ErrAddr;
                        state_d = StFin;
                    end else begin
                        state_d = StSetup;
                    end
                end
            end
            // A flag already up here is left over from an aborted operation.
            StSetup: state_d = flag_sync_q ? StFlush : StReq;
            StFlush: state_d = StFlushWait;
            StFlushWait: begin
                if (!flag_sync_q) begin
                    state_d = StReq;
                end else if (timer_expired) begin
                    err_d   = ErrTimeout;
                    state_d = StRelease;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            StReq: begin
                if (flag_sync_q) begin
                    state_d = StWb;
                end else if (timer_expired) begin
                    err_d   = ErrTimeout;
                    state_d = StRelease;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            StWb:      state_d = StRelease;
            StRelease: state_d = StClrWait;
            StClrWait: begin
                if (!flag_sync_q) begin
                    state_d = StFin;
                end else if (timer_expired) begin
                    // Memory never dropped its flag; give up rather than loop.
                    err_d   = ErrTimeout;
                    state_d = StFin;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Every wait state starts with a fresh count.
    assign timer_clr = (state_d != state_q);

    mem_req_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .inc    (timer_inc),
        .expired(timer_expired)
    );

    // Request controls and operands are held from SETUP through CLR_WAIT.
    assign ctrl_active = (state_q == StSetup)   || (state_q == StFlush) ||
                         (state_q == StFlushWait) || (state_q == StReq) ||
                         (state_q == StWb)      || (state_q == StRelease) ||
                         (state_q == StClrWait);

    assign bus.op_ready      = (state_q == StIdle);
    assign bus.memRead       = ctrl_active && (cls_q == OpLoad);
    assign bus.memWrite      = ctrl_active && (cls_q == OpStore);
    assign bus.memReadWrite  = ctrl_active && (cls_q == OpAlu);
    assign bus.result        = ctrl_active ? result_q : '0;
    assign bus.rd2           = ctrl_active ? rd2_q : '0;
    assign bus.isALUFinished = (state_q == StReq);
    assign bus.fetchNextInst = (state_q == StFlush) || (state_q == StRelease);

    // A store's response data carries nothing worth writing back.
    assign wb_fire     = (state_q == StWb) && (cls_q != OpStore);
    assign bus.wb_en   = wb_fire;
    assign bus.wb_addr = wb_fire ? dest_q : '0;
    assign bus.wb_data = wb_fire ? bus.rdata : '0;

    assign bus.done = (state_q == StFin);
    assign bus.err  = (state_q == StFin) ? err_q : ErrOk;

endmodule
